// File: rtl/game_fsm.sv
// Flappy-bird game sequencer: START/GAME/GAMEOVER screen state, datapath control
// pulses, BCD score and high score, and a frame-timed restart lockout after a crash.
module game_fsm #(
    parameter int GAMEOVER_HOLD_FRAMES = 120,
    parameter int SCORE_DIGITS         = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      frame_tick,
    input  logic                      btn_flap,
    input  logic                      collision,
    input  logic                      pipe_passed,
    output logic [1:0]                state,
    output logic                      run,
    output logic                      game_rst,
    output logic                      flap,
    output logic [4*SCORE_DIGITS-1:0] score,
    output logic [4*SCORE_DIGITS-1:0] high_score,
    output logic                      new_record
);

    localparam int SW = 4 * SCORE_DIGITS;
    localparam int HW = $clog2(GAMEOVER_HOLD_FRAMES + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(GAMEOVER_HOLD_FRAMES);

    typedef enum logic [1:0] {
        S_START = 2'b00,
        S_GAME  = 2'b01,
        S_OVER  = 2'b10,
        S_BAD   = 2'b11
    } state_t;

    state_t        cur;
    logic          btn_q;
    logic [HW-1:0] hold;
    logic          btn_rise;

    assign btn_rise = btn_flap & ~btn_q;
    assign state    = cur;

    // BCD increment with per-digit carry; an all-nines score is returned unchanged.
    function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
        logic [SW-1:0] r;
        logic          carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < SCORE_DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        if (carry) r = v;
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur        <= S_START;
            run        <= 1'b0;
            game_rst   <= 1'b0;
            flap       <= 1'b0;
            new_record <= 1'b0;
            score      <= '0;
            high_score <= '0;
            hold       <= '0;
            btn_q      <= 1'b1;
        end else begin
            btn_q    <= btn_flap;
            game_rst <= 1'b0;
            flap     <= 1'b0;
            case (cur)
                S_START: begin
                    run <= 1'b0;
                    if (btn_rise) begin
                        cur      <= S_GAME;
                        run      <= 1'b1;
                        game_rst <= 1'b1;
                        score    <= '0;
                    end
                end
                S_GAME: begin
                    run <= 1'b1;
                    // A crash overrides any flap or pipe credit arriving in the same cycle.
                    if (collision) begin
                        cur  <= S_OVER;
                        run  <= 1'b0;
                        hold <= HOLD_LOAD;
                        if (score > high_score) begin
                            high_score <= score;
                            new_record <= 1'b1;
                        end else begin
                            new_record <= 1'b0;
                        end
                    end else begin
                        if (btn_rise)    flap  <= 1'b1;
                        if (pipe_passed) score <= bcd_inc(score);
                    end
                end
                S_OVER: begin
                    run <= 1'b0;
                    if (hold != '0) begin
                        if (frame_tick) hold <= hold - 1'b1;
                    end else if (btn_rise) begin
                        cur        <= S_START;
                        new_record <= 1'b0;
                    end
                end
                default: begin
                    cur <= S_START;
                    run <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_fsm.sv
// Scoreboard bench for game_fsm: each scenario pushes expected output words as it
// drives stimulus and pops/compares them one cycle later.
module tb_game_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_tick;
    logic        btn_flap;
    logic        collision;
    logic        pipe_passed;
    logic [1:0]  state;
    logic        run;
    logic        game_rst;
    logic        flap;
    logic [11:0] score;
    logic [11:0] high_score;
    logic        new_record;

    game_fsm #(
        .GAMEOVER_HOLD_FRAMES(4),
        .SCORE_DIGITS(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .frame_tick(frame_tick),
        .btn_flap(btn_flap),
        .collision(collision),
        .pipe_passed(pipe_passed),
        .state(state),
        .run(run),
        .game_rst(game_rst),
        .flap(flap),
        .score(score),
        .high_score(high_score),
        .new_record(new_record)
    );

    always #5 clk = ~clk;

    typedef logic [29:0] obs_t;
    obs_t obs;
    assign obs = {state, run, game_rst, flap, new_record, score, high_score};

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [1:0] m_state;
    logic       m_run, m_grst, m_flap, m_rec;
    int         m_score, m_hi;

    function automatic logic [11:0] to_bcd(input int n);
        return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    function automatic obs_t model_word();
        return {m_state, m_run, m_grst, m_flap, m_rec, to_bcd(m_score), to_bcd(m_hi)};
    endfunction

    task automatic push_and_step();
        exp_q.push_back(model_word());
        @(negedge clk);
    endtask

    task automatic test_reset();
        obs_t want;
        @(negedge clk);
        @(negedge clk);
        {m_state, m_run, m_grst, m_flap, m_rec} = '0;
        m_score = 0;
        m_hi    = 0;
        exp_q.push_back(model_word());
        want = exp_q.pop_front();
        checks++;
        if (obs !== want) begin
            errors++;
            $display("[TB] FAIL reset_values: got %h, expected %h", obs, want);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) btn_flap = 1'b0;
            push_and_step();
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("[TB] FAIL held_btn_no_start[%0d]: got %h, expected %h", i, obs, want);
            end
        end
    endtask

    task automatic test_enter_game();
        obs_t want;
        for (int i = 0; i < 3; i++) begin
            btn_flap = (i < 2);
            m_state  = 2'b01;
            m_run    = 1'b1;
            m_grst   = (i == 0);
            m_flap   = 1'b0;
            m_score  = 0;
            push_and_step();
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("[TB] FAIL enter_game[%0d]: got %h, expected %h", i, obs, want);
            end
        end
    endtask

    task automatic test_flap();
        obs_t want;
        int   n;
        for (int i = 0; i < 6; i++) begin
            btn_flap = (i % 2 == 0);
            m_flap   = (i % 2 == 0);
            push_and_step();
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("[TB] FAIL flap_press[%0d]: got %h, expected %h", i, obs, want);
            end
        end
        n        = 0;
        btn_flap = 1'b1;
        for (int i = 0; i < 100; i++) begin
            m_flap = (i == 0);
            push_and_step();
            if (flap) n++;
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("[TB] FAIL flap_hold[%0d]: got %h, expected %h", i, obs, want);
            end
        end
        checks++;
        if (n !== 1) begin
            errors++;
            $display("[TB] FAIL flap_hold_count: got %0d pulses, expected 1", n);
        end
        btn_flap = 1'b0;
        m_flap   = 1'b0;
        push_and_step();
        want = exp_q.pop_front();
        checks++;
        if (obs !== want) begin
            errors++;
            $display("[TB] FAIL flap_release: got %h, expected %h", obs, want);
        end
    endtask

    task automatic test_crash(input int passes, input logic same_cycle);
        obs_t want;
        for (int i = 0; i < 2 * passes; i++) begin
            pipe_passed = (i % 2 == 0);
            if (i % 2 == 0) m_score++;
            push_and_step();
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("[TB] FAIL crash_scoring[%0d]: got %h, expected %h", i, obs, want);
            end
        end
        collision   = 1'b1;
        pipe_passed = same_cycle;
        btn_flap    = same_cycle;
        m_state     = 2'b10;
        m_run       = 1'b0;
        m_flap      = 1'b0;
        if (m_score > m_hi) begin
            m_hi  = m_score;
            m_rec = 1'b1;
        end else begin
            m_rec = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            push_and_step();
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("[TB] FAIL crash_gameover[%0d]: got %h, expected %h", i, obs, want);
            end
            collision   = 1'b0;
            pipe_passed = 1'b0;
            btn_flap    = 1'b0;
        end
    endtask

    task automatic test_hold();
        obs_t want;
        logic [1:0] ft_seq  [12] = '{1, 0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0};
        logic       btn_seq [12] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 0};
        for (int i = 0; i < 12; i++) begin
            frame_tick = ft_seq[i][0];
            btn_flap   = btn_seq[i];
            if (i == 10) begin
                m_state = 2'b00;
                m_rec   = 1'b0;
            end
            push_and_step();
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("[TB] FAIL hold_lockout[%0d]: got %h, expected %h", i, obs, want);
            end
        end
        frame_tick = 1'b0;
    endtask

    task automatic test_leave_gameover();
        obs_t want;
        for (int i = 0; i < 10; i++) begin
            frame_tick = (i < 8) && (i % 2 == 0);
            btn_flap   = (i == 8);
            if (i == 8) begin
                m_state = 2'b00;
                m_rec   = 1'b0;
            end
            push_and_step();
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("[TB] FAIL leave_gameover[%0d]: got %h, expected %h", i, obs, want);
            end
        end
        frame_tick = 1'b0;
        btn_flap   = 1'b0;
    endtask

    task automatic test_score_sat();
        obs_t want;
        for (int i = 0; i < 20; i++) begin
            pipe_passed = (i % 2 == 0);
            if (i % 2 == 0) m_score++;
            push_and_step();
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("[TB] FAIL score_count[%0d]: got %h, expected %h", i, obs, want);
            end
        end
        checks++;
        if (score !== 12'h010) begin
            errors++;
            $display("[TB] FAIL score_ten: got %h, expected 010", score);
        end
        pipe_passed = 1'b1;
        for (int i = 0; i < 990; i++) begin
            if (m_score < 999) m_score++;
            push_and_step();
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("[TB] FAIL score_sat[%0d]: got %h, expected %h", i, obs, want);
            end
        end
        pipe_passed = 1'b0;
        checks++;
        if (score !== 12'h999) begin
            errors++;
            $display("[TB] FAIL score_saturated: got %h, expected 999", score);
        end
        #2;
        rst_n = 1'b0;
        #1;
        {m_state, m_run, m_grst, m_flap, m_rec} = '0;
        m_score = 0;
        m_hi    = 0;
        exp_q.push_back(model_word());
        want = exp_q.pop_front();
        checks++;
        if (obs !== want) begin
            errors++;
            $display("[TB] FAIL async_reset: got %h, expected %h", obs, want);
        end
        @(negedge clk);
        rst_n = 1'b1;
        push_and_step();
        want = exp_q.pop_front();
        checks++;
        if (obs !== want) begin
            errors++;
            $display("[TB] FAIL after_reset: got %h, expected %h", obs, want);
        end
    endtask

    task automatic test_back_to_back();
        obs_t want;
        for (int i = 0; i < 4; i++) begin
            btn_flap    = (i % 2 == 0);
            pipe_passed = 1'b1;
            m_flap      = (i % 2 == 0);
            m_score++;
            push_and_step();
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("[TB] FAIL back_to_back[%0d]: got %h, expected %h", i, obs, want);
            end
        end
        btn_flap    = 1'b0;
        pipe_passed = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b1;
        btn_flap    = 1'b1;
        frame_tick  = 1'b0;
        collision   = 1'b0;
        pipe_passed = 1'b0;
        #1;
        rst_n = 1'b0;
        test_reset();
        test_enter_game();
        test_flap();
        test_crash(7, 1'b0);
        test_hold();
        test_enter_game();
        test_crash(5, 1'b0);
        test_leave_gameover();
        test_enter_game();
        test_crash(4, 1'b1);
        test_leave_gameover();
        test_enter_game();
        test_score_sat();
        test_enter_game();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_fsm.md
Name: game_fsm

Overview:
Top-level game sequencer for the flappy-bird design. It produces the 2-bit screen state that drives the screen-select mux: 00 START, 01 GAME, 10 GAMEOVER. It also turns player and collision events into the control pulses used by the bird/pipe datapath. It keeps a BCD score, a BCD high score and a post-crash restart lockout timed in video frames.

Parameters:
GAMEOVER_HOLD_FRAMES, 120, number of frame_tick pulses after a crash before a restart press is accepted (must be ≥ 1)
SCORE_DIGITS, 3, number of BCD digits in score and high_score

Ports:
clk  in  1  system/pixel clock
rst_n  in  1  asynchronous active-low reset
frame_tick  in  1  one-cycle pulse per video frame (start of vblank)
btn_flap  in  1  synchronized, debounced button level
collision  in  1  level from collision detector, high while bird overlaps pipe/ground
pipe_passed  in  1  one-cycle pulse when bird clears a pipe
state  out  2  screen state to the screen-select mux: 00 START, 01 GAME, 10 GAMEOVER
run  out  1  high while state==GAME; enables physics and pipe scrolling
game_rst  out  1  one-cycle pulse that reinitialises bird and pipes
flap  out  1  one-cycle flap request to bird physics
score  out  4*SCORE_DIGITS  current score, BCD, digit 0 in LSBs
high_score  out  4*SCORE_DIGITS  best score since reset, BCD
new_record  out  1  high during GAMEOVER if the last game set a new high score

Behaviour:
- Reset values (asynchronous on rst_n low):
  - state = START; run, game_rst, flap, new_record = 0; score, high_score = 0; hold counter = 0.
  - Button-history register = 1, so a button held through reset is not seen as a press.
- All outputs are registered. Every response appears on the cycle after the causing input is sampled.
- btn_rise = btn_flap & ~btn_q, where btn_q is btn_flap delayed one cycle. Holding the button produces exactly one rise.
- START:
  - On btn_rise: go to GAME, pulse game_rst for one cycle, clear score to 0.
  - No flap is generated by this press.
  - collision, pipe_passed and frame_tick are ignored.
- GAME:
  - run = 1.
  - btn_rise produces a one-cycle flap pulse.
  - pipe_passed increments score in BCD with per-digit carry.
  - Score saturates at all digits = 9 and never wraps.
  - collision = 1: go to GAMEOVER, load hold counter with GAMEOVER_HOLD_FRAMES.
  - Also on collision, if score > high_score (BCD compare, equal to binary compare): high_score ← score, new_record ← 1.
  - Collision and pipe_passed in the same cycle: collision wins and score is not incremented.
  - Collision and btn_rise in the same cycle: no flap.
- GAMEOVER:
  - run = 0; score and high_score are held.
  - Each frame_tick decrements the hold counter while it is nonzero.
  - btn_rise while counter ≠ 0 is ignored.
  - btn_rise while counter = 0: go to START, clear new_record.
  - A btn_rise in the same cycle the counter reaches 0 is ignored; the counter must already read 0.
- State 11 is unreachable. If it is ever entered, return to START on the next cycle with run = 0.
- Hold counter width is $clog2(GAMEOVER_HOLD_FRAMES+1).
- Reset asserted mid-game drops immediately to START with all values cleared, including high_score.

Test Plan:
- Reset with btn_flap held high, then release and press → no transition until the fresh rise; on that rise state 00→01 next cycle, game_rst high exactly 1 cycle, flap stays 0.
- In GAME, 3 presses → 3 single-cycle flap pulses. Holding the button 100 cycles → only 1 pulse.
- In GAME, 10 pipe_passed pulses → score = 0x010. Preload to 999 plus one pulse → score stays 0x999.
- Score 0x007, collision → state 10, high_score = 0x007, new_record = 1. Next game scoring 0x005 then crashing → high_score stays 0x007, new_record = 0.
- collision and pipe_passed asserted in the same cycle with score 0x004 → GAMEOVER, score remains 0x004.
- GAMEOVER with GAMEOVER_HOLD_FRAMES = 4:
  - Presses after 2 frame_ticks are ignored.
  - A press after the 4th frame_tick → state 00, new_record cleared.
  - rst_n pulsed low mid-GAME → state 00, score 0, high_score 0 asynchronously.
